// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and backend-side signals for the memory port arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the
// environment, which is the requesters plus the backend.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  logic        busy;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter. An instruction-fetch port and a data port
// share one backend. Data has priority, but only for a bounded streak while a
// fetch is waiting. Every output is a register. The backend sees at most one
// transaction at a time.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_arbiter_if.master  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [2:0] STREAK_MAX = 3'(MAX_D_STREAK);

  logic [1:0] state;
  logic [2:0] streak;
  logic       grant_data;

  // Data wins unless a fetch is waiting and data has used up its streak
  always_comb begin
    grant_data = bus.d_req && (!bus.i_req || (streak < STREAK_MAX));
  end

  // Arbitration FSM with registered backend request, completion pulses and read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      streak      <= 3'd0;
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= 32'd0;
      bus.m_wdata <= 32'd0;
      bus.i_rdata <= 32'd0;
      bus.d_rdata <= 32'd0;
      bus.i_ready <= 1'b0;
      bus.d_ready <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            state       <= SERVE_D;
            bus.m_req   <= 1'b1;
            bus.m_we    <= bus.d_we;
            bus.m_addr  <= bus.d_addr;
            bus.m_wdata <= bus.d_wdata;
            bus.busy    <= 1'b1;
            streak      <= bus.i_req ? streak + 3'd1 : 3'd0;
          end else if (bus.i_req) begin
            state      <= SERVE_I;
            bus.m_req  <= 1'b1;
            bus.m_we   <= 1'b0;
            bus.m_addr <= bus.i_addr;
            bus.busy   <= 1'b1;
            streak     <= 3'd0;
          end
        end
        SERVE_I: begin
          if (bus.m_ack) begin
            state       <= DONE;
            bus.m_req   <= 1'b0;
            bus.i_rdata <= bus.m_rdata;
            bus.i_ready <= 1'b1;
          end
        end
        SERVE_D: begin
          if (bus.m_ack) begin
            state       <= DONE;
            bus.m_req   <= 1'b0;
            bus.d_ready <= 1'b1;
            if (!bus.m_we) begin
              bus.d_rdata <= bus.m_rdata;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          bus.i_ready <= 1'b0;
          bus.d_ready <= 1'b0;
          bus.busy    <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A transaction-level model tracks
// the pending requests, the data streak and the expected read data. Each grant,
// stall, completion and idle cycle is checked against that model.
module tb_mem_port_arbiter;

  localparam int MAX_D_STREAK = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_D_STREAK(MAX_D_STREAK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int failures = 0;

  logic        i_pend, d_pend, d_write;
  logic [31:0] i_addr_m, d_addr_m, d_wdata_m;
  logic [31:0] exp_i_rdata, exp_d_rdata;
  int          model_streak;

  // Count one comparison and report it if observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive the requester inputs from the model's pending-request state
  task automatic applyStimulus();
    bus.i_req   = i_pend;
    bus.i_addr  = i_addr_m;
    bus.d_req   = d_pend;
    bus.d_we    = d_write;
    bus.d_addr  = d_addr_m;
    bus.d_wdata = d_wdata_m;
  endtask

  task automatic newFetch(input logic [31:0] addr);
    i_pend   = 1'b1;
    i_addr_m = addr;
    applyStimulus();
  endtask

  task automatic newData(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    d_pend    = 1'b1;
    d_write   = we;
    d_addr_m  = addr;
    d_wdata_m = wdata;
    applyStimulus();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_m_req"},   bus.m_req,   32'd0);
    checkOutput({tag, "_m_we"},    bus.m_we,    32'd0);
    checkOutput({tag, "_m_addr"},  bus.m_addr,  32'd0);
    checkOutput({tag, "_m_wdata"}, bus.m_wdata, 32'd0);
    checkOutput({tag, "_i_rdata"}, bus.i_rdata, 32'd0);
    checkOutput({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
    checkOutput({tag, "_ready"},   {bus.i_ready, bus.d_ready}, 32'd0);
    checkOutput({tag, "_busy"},    bus.busy,    32'd0);
  endtask

  // Called during an IDLE cycle with at least one request pending; returns in the next IDLE cycle
  task automatic runTransaction(input int stall, input logic [31:0] rdata, input logic noise,
                                output logic served_data);
    logic        exp_data;
    logic [31:0] exp_addr;
    exp_data = d_pend && (!i_pend || model_streak < MAX_D_STREAK);
    exp_addr = exp_data ? d_addr_m : i_addr_m;
    if (exp_data) model_streak = i_pend ? model_streak + 1 : 0;
    else          model_streak = 0;

    @(posedge clk); #1;
    bus.m_ack = 1'b0;
    checkOutput("grant_m_req",  bus.m_req,  32'd1);
    checkOutput("grant_m_addr", bus.m_addr, exp_addr);
    checkOutput("grant_m_we",   bus.m_we,   exp_data ? d_write : 1'b0);
    if (exp_data && d_write) checkOutput("grant_m_wdata", bus.m_wdata, d_wdata_m);
    checkOutput("grant_busy",   bus.busy,   32'd1);

    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      checkOutput("stall_m_req",  bus.m_req,  32'd1);
      checkOutput("stall_m_addr", bus.m_addr, exp_addr);
      checkOutput("stall_busy",   bus.busy,   32'd1);
      checkOutput("stall_ready",  {bus.i_ready, bus.d_ready}, 32'd0);
    end

    bus.m_ack   = 1'b1;
    bus.m_rdata = rdata;
    @(posedge clk); #1;
    bus.m_ack   = noise;
    bus.m_rdata = $urandom;
    if (exp_data) begin
      if (!d_write) exp_d_rdata = rdata;
    end else begin
      exp_i_rdata = rdata;
    end
    checkOutput("done_i_ready", bus.i_ready, !exp_data);
    checkOutput("done_d_ready", bus.d_ready, exp_data);
    checkOutput("done_i_rdata", bus.i_rdata, exp_i_rdata);
    checkOutput("done_d_rdata", bus.d_rdata, exp_d_rdata);
    checkOutput("done_m_req",   bus.m_req,   32'd0);
    if (exp_data) d_pend = 1'b0;
    else          i_pend = 1'b0;
    applyStimulus();

    @(posedge clk); #1;
    bus.m_ack = 1'b0;
    checkOutput("idle_ready",   {bus.i_ready, bus.d_ready}, 32'd0);
    checkOutput("idle_busy",    bus.busy,    32'd0);
    checkOutput("idle_m_req",   bus.m_req,   32'd0);
    checkOutput("idle_i_rdata", bus.i_rdata, exp_i_rdata);
    checkOutput("idle_d_rdata", bus.d_rdata, exp_d_rdata);
    served_data = exp_data;
  endtask

  // Directed scenarios followed by a randomized transaction stream
  initial begin
    logic served;
    int   data_grants;
    rst = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; d_write = 1'b0;
    i_addr_m = '0; d_addr_m = '0; d_wdata_m = '0;
    exp_i_rdata = '0; exp_d_rdata = '0; model_streak = 0;
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    applyStimulus();

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b1;

    // Fetch only, acknowledged in cycle 3
    newFetch(32'h40);
    runTransaction(2, 32'h2008_0005, 1'b0, served);

    // Simultaneous requests: the data write goes first, then the fetch
    newFetch(32'h0000_0200);
    newData(1'b1, 32'h10, 32'hDEAD_BEEF);
    runTransaction(1, 32'h1111_2222, 1'b1, served);
    runTransaction(0, 32'h3333_4444, 1'b0, served);

    // Starvation bound: data is requested continuously while a fetch waits
    newFetch(32'h0000_0100);
    data_grants = 0;
    for (int n = 0; n < 6; n++) begin
      if (!d_pend) newData(n[0], 32'h8000_1000 + 32'(n * 4), $urandom);
      runTransaction(1, $urandom, 1'b0, served);
      if (served) data_grants++;
      if (n == 4) begin
        newFetch(32'h0000_0104);
      end
    end

    // Backend stall of ten cycles
    newFetch(32'h0000_0300);
    runTransaction(10, 32'hCAFE_F00D, 1'b0, served);

    // Reset in the middle of a data read
    newData(1'b0, 32'h8000_0020, 32'h0);
    @(posedge clk); #1;
    checkOutput("rst_grant_m_req", bus.m_req, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkAllZero("rst_mid");
    d_pend = 1'b0; i_pend = 1'b0; applyStimulus();
    model_streak = 0; exp_i_rdata = '0; exp_d_rdata = '0;
    #1;
    rst = 1'b1;
    bus.m_ack = 1'b1; bus.m_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.m_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput("rst_late_ack_ready", {bus.i_ready, bus.d_ready}, 32'd0);
      checkOutput("rst_late_ack_busy",  bus.busy,    32'd0);
      checkOutput("rst_late_ack_d_rd",  bus.d_rdata, 32'd0);
      @(posedge clk); #1;
    end

    // Randomized stream with ack noise in IDLE and DONE
    for (int t = 0; t < 80; t++) begin
      if (!i_pend && ($urandom % 2 == 0)) newFetch({1'b0, 31'($urandom) & 31'h7FFF_FFFC});
      if (!d_pend && ($urandom % 4 != 0)) newData(1'($urandom), {1'b1, 31'($urandom)}, $urandom);
      bus.m_ack = 1'($urandom);
      if (!i_pend && !d_pend) begin
        @(posedge clk); #1;
        checkOutput("empty_m_req", bus.m_req, 32'd0);
        checkOutput("empty_busy",  bus.busy,  32'd0);
        newFetch({1'b0, 31'($urandom) & 31'h7FFF_FFFC});
      end
      runTransaction(int'($urandom_range(0, 4)), $urandom, 1'($urandom), served);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_D_STREAK, 4, maximum consecutive data grants while an instruction request is pending (range 1..7).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 i_req  input  1  instruction-fetch read request.
REQ-005 i_addr  input  32  fetch byte address.
REQ-006 i_rdata  output  32  fetch data; valid when i_ready=1.
REQ-007 i_ready  output  1  one-cycle fetch completion pulse.
REQ-008 d_req  input  1  data-port request.
REQ-009 d_we  input  1  1 = write, 0 = read.
REQ-010 d_addr  input  32  data byte address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_rdata  output  32  load data; valid when d_ready=1 after a read.
REQ-013 d_ready  output  1  one-cycle data completion pulse.
REQ-014 m_req, m_we  output  1 each  backend request and write enable.
REQ-015 m_addr, m_wdata  output  32 each  backend address and store data.
REQ-016 m_rdata  input  32  backend read data; valid with m_ack.
REQ-017 m_ack  input  1  backend one-cycle completion.
REQ-018 busy  output  1  1 whenever state is not IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, SERVE_I, SERVE_D and DONE; all outputs SHALL be registered.
REQ-020 In IDLE, d_req=1 with (i_req=0 or streak<MAX_D_STREAK) SHALL grant data: latch d_we/d_addr/d_wdata into m_we/m_addr/m_wdata, set m_req=1, go to SERVE_D.
REQ-021 In IDLE, when REQ-020 does not grant and i_req=1, the FSM SHALL grant fetch: latch i_addr, m_we=0, m_req=1, go to SERVE_I.
REQ-022 With no request in IDLE, the FSM SHALL stay in IDLE with m_req=0.
REQ-023 streak (3-bit) SHALL increment on a data grant while i_req=1, clear on a data grant while i_req=0, and clear on any fetch grant.
REQ-024 In SERVE_I and SERVE_D, m_req, m_we, m_addr and m_wdata SHALL hold stable until m_ack=1 is sampled; requester inputs SHALL be ignored.
REQ-025 When m_ack=1 is sampled in SERVE_x, the FSM SHALL deassert m_req, capture m_rdata into i_rdata (SERVE_I) or into d_rdata (SERVE_D read only), and go to DONE.
REQ-026 In DONE, the matching i_ready or d_ready SHALL be 1 for exactly that cycle, and the FSM SHALL then go to IDLE.
REQ-027 A data write SHALL pulse d_ready and leave d_rdata unchanged.
REQ-028 i_rdata and d_rdata SHALL hold their last captured values between completions.
REQ-029 Requesters SHALL hold req and operands until ready; a new request is legal from the cycle after ready.
REQ-030 m_ack SHALL be ignored in IDLE and DONE.
REQ-031 Latency: grant edge at cycle 0 (m_req=1 from cycle 1); ack sampled at cycle k; ready=1 in cycle k+1. There SHALL be a minimum of one IDLE cycle between transactions.
REQ-032 i_ready and d_ready SHALL never both be 1; at most one backend transaction SHALL be outstanding.

Reset
REQ-033 While rst=0, the block SHALL immediately force: state=IDLE, streak=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, i_rdata=0, d_rdata=0, i_ready=0, d_ready=0, busy=0.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction without a ready pulse; any late m_ack after reset release SHALL be ignored.
REQ-035 After rst returns to 1, arbitration SHALL resume from the first rising edge.

Verification
REQ-036 Fetch only: i_req=1, i_addr=0x40; ack in cycle 3 with m_rdata=0x20080005 -> m_addr=0x40, m_we=0; i_ready pulses in cycle 4 with i_rdata=0x20080005.
REQ-037 Simultaneous requests: i_req=d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> data is granted first with m_we=1 and m_wdata=0xDEADBEEF; d_ready pulses with d_rdata unchanged; the fetch is then served.
REQ-038 Starvation bound: d_req held continuously with i_req=1 and MAX_D_STREAK=4 -> exactly 4 data grants, then one fetch grant, then streak=0.
REQ-039 Backend stall: m_ack withheld for 10 cycles -> m_req and m_addr stay stable and busy=1 throughout; exactly one ready pulse follows.
REQ-040 Reset mid-transaction: rst=0 during SERVE_D, then an m_ack pulse after release -> all outputs are 0 immediately; no d_ready pulse; the state stays IDLE.
REQ-041 Back-to-back requests: a new i_req in the cycle after i_ready -> the next grant occurs from IDLE on the following edge with no duplicate service of the old request.
